// File: rtl/pipelined_bitwise_logic_unit.sv
// Two-stage WIDTH-bit bitwise logic unit with valid/ready flow control, zero and parity flags.
// Define BLU_ACCUM_EN to let an op take the previous op's result as operand A.
module pipelined_bitwise_logic_unit #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [2:0]       out_op
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } blu_op_e;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Ready never depends on the same port's valid; a producer holds its data until it transfers.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic [2:0]       s2_op_q, s2_op_d;

  logic             adv;
  logic             accept;
  logic             s1_move;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] func_result;

  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = !clr && (!s1_valid_q || adv);
  assign accept   = in_valid && in_ready;
  assign s1_move  = s1_valid_q && adv && !clr;

`ifdef BLU_ACCUM_EN
  logic             s1_acc_q, s1_acc_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // acc always holds the result of the most recent op to leave S1.
  assign op_a = s1_acc_q ? acc_q : s1_a_q;

  always_comb begin
    s1_acc_d = s1_acc_q;
    acc_d    = acc_q;
    if (accept) s1_acc_d = in_acc;
    if (clr) acc_d = '0;
    else if (s1_move) acc_d = func_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_acc_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      s1_acc_q <= s1_acc_d;
      acc_q    <= acc_d;
    end
  end
`else
  logic unused_in_acc;
  assign unused_in_acc = in_acc;
  assign op_a          = s1_a_q;
`endif

  always_comb begin
    func_result = '0;
    case (blu_op_e'(s1_op_q))
      OP_AND:  func_result = op_a & s1_b_q;
      OP_OR:   func_result = op_a | s1_b_q;
      OP_XOR:  func_result = op_a ^ s1_b_q;
      OP_NAND: func_result = ~(op_a & s1_b_q);
      OP_NOR:  func_result = ~(op_a | s1_b_q);
      OP_XNOR: func_result = ~(op_a ^ s1_b_q);
      OP_ANDN: func_result = op_a & ~s1_b_q;
      OP_PASS: func_result = op_a;
      default: func_result = '0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_op_d     = s2_op_q;

    if (accept) begin
      s1_a_d  = in_a;
      s1_b_d  = in_b;
      s1_op_d = in_op;
    end

    // clr wins over every handshake; data registers may keep stale values.
    if (clr) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept) s1_valid_d = 1'b1;
      else if (s1_valid_q && adv) s1_valid_d = 1'b0;
      if (adv) s2_valid_d = s1_valid_q;
    end

    if (s1_move) begin
      s2_result_d = func_result;
      s2_op_d     = s1_op_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_op_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_op_q     <= s2_op_d;
    end
  end

  // Flags derive from the held result, so they stay stable under backpressure.
  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_op     = s2_op_q;
  assign out_zero   = ~|s2_result_q;
  assign out_parity = ^s2_result_q;

endmodule

// File: tb/tb_pipelined_bitwise_logic_unit.sv
// Directed and scoreboard-checked bench for pipelined_bitwise_logic_unit at WIDTH=20.
// Accumulator chain checks are compiled in when BLU_ACCUM_EN is defined.
module tb_pipelined_bitwise_logic_unit;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         in_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_parity;
  logic [2:0]   out_op;

  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;
  logic [24:0] exp_q[$];
  logic [W-1:0] model_acc = '0;

  pipelined_bitwise_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_parity(out_parity), .out_op(out_op)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: ref_fn = a & b;
      3'd1: ref_fn = a | b;
      3'd2: ref_fn = a ^ b;
      3'd3: ref_fn = ~(a & b);
      3'd4: ref_fn = ~(a | b);
      3'd5: ref_fn = ~(a ^ b);
      3'd6: ref_fn = a & ~b;
      default: ref_fn = a;
    endcase
  endfunction

  // scoreboard: push on accept, pop and compare on output handshake
  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] a_eff;
    logic [W-1:0] r;
    logic [24:0]  e;
    if (!rst_n) begin
      exp_q.delete();
      model_acc = '0;
    end else begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("sb_out", {7'd0, out_parity, out_zero, out_op, out_result}, {7'd0, e});
        end
      end
      if (clr) begin
        exp_q.delete();
        model_acc = '0;
      end else if (in_valid && in_ready) begin
        a_eff = in_a;
`ifdef BLU_ACCUM_EN
        if (in_acc) a_eff = model_acc;
`endif
        r = ref_fn(a_eff, in_b, in_op);
        model_acc = r;
        exp_q.push_back({^r, (r == '0), in_op, r});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic acc);
    int n;
    in_a = a; in_b = b; in_op = op; in_acc = acc; in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    int n_acc;
    int pops0;
    int accepted;
    int cyc;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_op = '0; in_acc = 1'b0; out_ready = 1'b0;

    // reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_out_parity", out_parity, 0);
    check("rst_out_op", out_op, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_zero", out_zero, 1);

    // first op and two-cycle latency
    out_ready = 1'b1;
    drive_op(20'h0005F, 20'h00000, 3'd0, 1'b0);
    in_valid = 1'b0;
    check("lat_not_yet", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("and_result", out_result, 20'h00000);
    check("and_zero", out_zero, 1);
    check("and_parity", out_parity, 0);
    tick();

    // back-to-back AND, OR, XOR
    drive_op(20'hC0003, 20'hC0003, 3'd0, 1'b0);
    drive_op(20'hC0003, 20'hC0003, 3'd1, 1'b0);
    check("b2b_and", out_result, 20'hC0003);
    check("b2b_and_par", out_parity, 0);
    check("b2b_and_op", out_op, 0);
    drive_op(20'hC0003, 20'hC0003, 3'd2, 1'b0);
    check("b2b_or", out_result, 20'hC0003);
    check("b2b_or_op", out_op, 1);
    in_valid = 1'b0;
    tick();
    check("b2b_xor", out_result, 20'h00000);
    check("b2b_xor_zero", out_zero, 1);
    check("b2b_xor_op", out_op, 2);
    drain("b2b_drain");

    // backpressure: 3 ANDN ops offered, out_ready low for 5 cycles
    out_ready = 1'b0;
    pops0 = pop_cnt;
    in_a = 20'hFFFFF; in_b = 20'h0000F; in_op = 3'd6; in_acc = 1'b0; in_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      if (in_ready) n_acc++;
      #1;
      if (i >= 2) check("stall_hold", out_result, 20'hFFFF0);
    end
    check("stall_accepted", n_acc, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("push_pop_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain("stall_drain");
    check("stall_pops", pop_cnt - pops0, 3);

    // random stream against the scoreboard
    pops0 = pop_cnt;
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = W'($urandom_range(0, 20'hFFFFF));
        in_b = W'($urandom_range(0, 20'hFFFFF));
        in_op = 3'($urandom_range(0, 7));
        in_acc = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) check("rand_push_pop_ready", in_ready, 1);
      @(posedge clk);
      if (in_valid && in_ready) accepted++;
      #1;
      cyc++;
    end
    check("rand_accepted", accepted, 1000);
    drain("rand_drain");
    check("rand_pops", pop_cnt - pops0, 1000);

    // clr with two ops in flight
    out_ready = 1'b0;
    drive_op(20'h12345, 20'h0FFFF, 3'd1, 1'b0);
    drive_op(20'h12345, 20'h0FFFF, 3'd2, 1'b0);
    clr = 1'b1;
    in_a = 20'h11111;
    #1;
    check("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", out_valid, 0);
    tick();
    check("clr_s1_dropped", out_valid, 0);
    out_ready = 1'b1;
    pops0 = pop_cnt;
    drive_op(20'hAAAAA, 20'h55555, 3'd2, 1'b0);
    in_valid = 1'b0;
    tick();
    check("post_clr_result", out_result, 20'hFFFFF);
    check("post_clr_parity", out_parity, 0);
    check("post_clr_zero", out_zero, 0);
    drain("clr_drain");
    check("post_clr_pops", pop_cnt - pops0, 1);

`ifdef BLU_ACCUM_EN
    // accumulator chain at full rate
    drive_op(20'hFFFFF, 20'h0F0F0, 3'd0, 1'b0);
    drive_op(20'h00000, 20'h000FF, 3'd1, 1'b1);
    check("acc_op1", out_result, 20'h0F0F0);
    drive_op(20'h00000, 20'hFFFFF, 3'd2, 1'b1);
    check("acc_op2", out_result, 20'h0F0FF);
    in_valid = 1'b0;
    tick();
    check("acc_op3", out_result, 20'hF0F00);
    drain("acc_drain");
`endif

    // async reset mid-stream; acc (if present) holds 0xFFFFF before it
    out_ready = 1'b0;
    drive_op(20'hFFFFF, 20'h00000, 3'd7, 1'b0);
    drive_op(20'hFFFFF, 20'h00000, 3'd7, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_out_zero", out_zero, 1);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive_op(20'h00000, 20'h12345, 3'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    check("post_midrst_valid", out_valid, 1);
    check("post_midrst_result", out_result, 20'h12345);
    drain("midrst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
